// File: rtl/sa_arb_pkg.sv
// sa_arb_pkg: shared FSM state encoding and per-channel address helper for the SA tile write path.
//   sa_state_t : IDLE / WRITE / TDONE / PAUSE
//   ch_addr()  : address of channel ch given the row address and the fixed channel offset
package sa_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, TDONE = 2'd2, PAUSE = 2'd3} sa_state_t;
   function automatic logic [31:0] ch_addr(input logic [31:0] row_addr, input int ch, input int ch_offset);
      return row_addr + 32'(ch * ch_offset);
   endfunction
endpackage

// File: rtl/sa_addr_accum.sv
// sa_addr_accum: loadable address accumulator (load has priority over add).
//   clk, rst_n   : clock, async active-low reset
//   i_load       : load i_load_val
//   i_load_val   : value to load
//   i_en         : add i_step
//   i_step       : increment
//   o_acc        : accumulated value (wraps modulo 2^W)
module sa_addr_accum #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic [W-1:0] i_step,
   output logic [W-1:0] o_acc
);
   logic [W-1:0] r_acc;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_acc <= '0;
      else if (i_load) r_acc <= i_load_val;
      else if (i_en) r_acc <= r_acc + i_step;
   assign o_acc = r_acc;
endmodule

// File: rtl/sa_tile_write_addr_gen.sv
// sa_tile_write_addr_gen: multi-bank BRAM write-address generator for systolic-array output tiles.
//   clk, rst_n                 : clock, async active-low reset
//   start, abort               : begin/resume a tile sequence; return to IDLE
//   cfg_base/row_stride/tile_stride/rows/tiles/auto_next : sequence configuration, latched on start in IDLE
//   in_valid / in_ready        : one SA output row per beat
//   bram_we, bram_addr         : registered per-bank write enable and address (ch0 in LSBs)
//   tile_done, all_done        : one-cycle completion pulses
//   tile_idx, busy             : current tile index, not idle
//   Optional SA_WR_OVF_CHK_EN: adds cfg_limit input and sticky err output; out-of-range or wrapped beats are not written.
module sa_tile_write_addr_gen
   import sa_arb_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int CH_OFFSET  = 1,
   parameter int ROW_CNT_W  = 6,
   parameter int TILE_CNT_W = 9
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [ADDR_WIDTH-1:0]        cfg_base,
   input  logic [ADDR_WIDTH-1:0]        cfg_row_stride,
   input  logic [ADDR_WIDTH-1:0]        cfg_tile_stride,
   input  logic [ROW_CNT_W-1:0]         cfg_rows,
   input  logic [TILE_CNT_W-1:0]        cfg_tiles,
   input  logic                         cfg_auto_next,
`ifdef SA_WR_OVF_CHK_EN
   input  logic [ADDR_WIDTH-1:0]        cfg_limit,
   output logic                         err,
`endif
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [NUM_CH-1:0]            bram_we,
   output logic [NUM_CH*ADDR_WIDTH-1:0] bram_addr,
   output logic                         tile_done,
   output logic                         all_done,
   output logic [TILE_CNT_W-1:0]        tile_idx,
   output logic                         busy
);
   sa_state_t r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_base, r_row_stride, r_tile_stride, w_tile_base, w_row_addr, w_row_val, w_tile_val;
   logic [ROW_CNT_W-1:0] r_rows, r_row;
   logic [TILE_CNT_W-1:0] r_tiles, r_tile;
   logic r_auto, w_beat, w_last_row, w_last_tile, w_start_idle, w_tdone, w_wr, w_row_load, w_tile_load;
   logic [NUM_CH*ADDR_WIDTH-1:0] w_addr;

   assign w_beat       = in_valid & (r_state == WRITE);
   assign w_last_row   = r_row == r_rows;
   assign w_last_tile  = r_tile == r_tiles;
   assign w_start_idle = start & (r_state == IDLE);
   assign w_tdone      = r_state == TDONE;
   assign in_ready     = r_state == WRITE;
   assign busy         = r_state != IDLE;
   assign tile_idx     = r_tile;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(ch_addr(32'(w_row_addr), c, CH_OFFSET));
   end

   // Row address reloads at every tile boundary to the next tile base; after the last tile both
   // accumulators fall back to the latched base so a later start sees a clean state.
   assign w_row_load  = abort | w_start_idle | w_tdone;
   assign w_row_val   = abort ? '0 : w_start_idle ? cfg_base : w_last_tile ? r_base : w_tile_base + r_tile_stride;
   assign w_tile_load = abort | w_start_idle | (w_tdone & w_last_tile);
   assign w_tile_val  = abort ? '0 : w_start_idle ? cfg_base : r_base;

   sa_addr_accum #(.W(ADDR_WIDTH)) u_tile_acc (
      .clk(clk), .rst_n(rst_n), .i_load(w_tile_load), .i_load_val(w_tile_val),
      .i_en(w_tdone & ~w_last_tile), .i_step(r_tile_stride), .o_acc(w_tile_base)
   );
   sa_addr_accum #(.W(ADDR_WIDTH)) u_row_acc (
      .clk(clk), .rst_n(rst_n), .i_load(w_row_load), .i_load_val(w_row_val),
      .i_en(w_beat & ~w_last_row), .i_step(r_row_stride), .o_acc(w_row_addr)
   );

`ifdef SA_WR_OVF_CHK_EN
   logic [ADDR_WIDTH-1:0] r_limit;
   logic r_tile_wrap, r_row_wrap, r_err, w_ovf;
   logic [ADDR_WIDTH:0] w_hi, w_tb_sum, w_rs_sum;
   assign w_hi     = {1'b0, w_row_addr} + (ADDR_WIDTH+1)'((NUM_CH - 1) * CH_OFFSET);
   assign w_tb_sum = {1'b0, w_tile_base} + {1'b0, r_tile_stride};
   assign w_rs_sum = {1'b0, w_row_addr} + {1'b0, r_row_stride};
   // A row address is "wrapped" once any accumulation feeding it has carried out of ADDR_WIDTH.
   assign w_ovf    = r_row_wrap | w_hi[ADDR_WIDTH] | (w_hi[ADDR_WIDTH-1:0] > r_limit);
   assign w_wr     = w_beat & ~abort & ~w_ovf;
   assign err      = r_err;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_limit     <= '0;
         r_err       <= 1'b0;
         r_tile_wrap <= 1'b0;
         r_row_wrap  <= 1'b0;
      end else begin
         if (w_start_idle & ~abort) r_limit <= cfg_limit;
         r_err <= (abort | (start & (r_state == IDLE || r_state == PAUSE))) ? 1'b0 : r_err | (w_beat & w_ovf);
         if (abort | w_start_idle) begin
            r_tile_wrap <= 1'b0;
            r_row_wrap  <= 1'b0;
         end else if (w_tdone) begin
            r_tile_wrap <= ~w_last_tile & (r_tile_wrap | w_tb_sum[ADDR_WIDTH]);
            r_row_wrap  <= ~w_last_tile & (r_tile_wrap | w_tb_sum[ADDR_WIDTH]);
         end else if (w_beat & ~w_last_row) r_row_wrap <= r_row_wrap | w_rs_sum[ADDR_WIDTH];
      end
`else
   assign w_wr = w_beat & ~abort;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = start ? WRITE : IDLE;
         WRITE:   w_state_nxt = (w_beat & w_last_row) ? TDONE : WRITE;
         TDONE:   w_state_nxt = w_last_tile ? IDLE : r_auto ? WRITE : PAUSE;
         PAUSE:   w_state_nxt = start ? WRITE : PAUSE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state       <= IDLE;
         r_row         <= '0;
         r_tile        <= '0;
         r_base        <= '0;
         r_row_stride  <= '0;
         r_tile_stride <= '0;
         r_rows        <= '0;
         r_tiles       <= '0;
         r_auto        <= 1'b0;
         bram_we       <= '0;
         bram_addr     <= '0;
         tile_done     <= 1'b0;
         all_done      <= 1'b0;
      end else begin
         bram_we   <= {NUM_CH{w_wr}};
         tile_done <= ~abort & w_beat & w_last_row;
         all_done  <= ~abort & w_beat & w_last_row & w_last_tile;
         if (w_beat & ~abort) bram_addr <= w_addr;
         if (w_start_idle & ~abort) begin
            r_base        <= cfg_base;
            r_row_stride  <= cfg_row_stride;
            r_tile_stride <= cfg_tile_stride;
            r_rows        <= cfg_rows;
            r_tiles       <= cfg_tiles;
            r_auto        <= cfg_auto_next;
         end
         if (abort) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_tile  <= '0;
         end else begin
            r_state <= w_state_nxt;
            if (w_beat) r_row <= w_last_row ? '0 : r_row + 1'b1;
            if (w_tdone) r_tile <= w_last_tile ? '0 : r_tile + 1'b1;
         end
      end
endmodule
